imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 79 +++++++
 tb/tb_imem_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: serial boot loader that streams a length-prefixed, checksummed program into instruction memory.
// Ports: clk/reset (sync, active-high); start begins a session; byte_in/byte_valid/byte_ready form the
// serial byte handshake; imem_we/imem_addr/imem_wdata write one word per cycle; cpu_reset holds the core
// until a load succeeds; busy/done/error report session status.
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CSUM, DONE, ERROR} state_t;
    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [31:0] word_q, n_q, idx_q;
    logic [7:0]  csum_q;
    logic        xfer, launch, last_byte;
    logic [31:0] shifted;
    assign xfer      = byte_valid && byte_ready;
    assign launch    = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign last_byte = cnt_q == 2'd3;
    // Little-endian assembly: each new byte enters at the top, so after four bytes the first is the LSB.
    assign shifted   = {byte_in, word_q[31:8]};
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: state_d = start ? HDR : state_q;
            HDR:   if (xfer && last_byte)
                       state_d = shifted > 32'(DEPTH_WORDS) ? ERROR : shifted == 32'd0 ? CSUM : DATA;
            DATA:  if (xfer && last_byte) state_d = WRITE;
            WRITE: state_d = idx_q + 32'd1 < n_q ? DATA : CSUM;
            CSUM:  if (xfer) state_d = byte_in == csum_q ? DONE : ERROR;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        byte_ready = state_q == HDR || state_q == DATA || state_q == CSUM;
        imem_we    = state_q == WRITE;
        busy       = byte_ready || imem_we;
        done       = state_q == DONE;
        error      = state_q == ERROR;
        cpu_reset  = state_q != DONE;
        imem_addr  = BASE_ADDR + (idx_q << 2);
        imem_wdata = word_q;
    end
    // The header count and data words share the assembly register; a session launch wipes all of it.
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            cnt_q  <= '0;
            word_q <= '0;
            n_q    <= '0;
            idx_q  <= '0;
            csum_q <= '0;
        end else begin
            if (xfer && state_q != CSUM) begin
                word_q <= shifted;
                cnt_q  <= cnt_q + 2'd1;
            end
            if (xfer && state_q == DATA) csum_q <= csum_q ^ byte_in;
            if (xfer && state_q == HDR && last_byte) n_q <= shifted;
            if (state_q == WRITE) idx_q <= idx_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed self-checking bench for imem_loader against a queue-based model.
module tb_imem_loader;
    logic        clk = 0, reset = 1, start = 0, byte_valid = 0;
    logic [7:0]  byte_in = 0;
    logic        byte_ready, imem_we, cpu_reset, busy, done, error;
    logic [31:0] imem_addr, imem_wdata;
    logic        byte_ready1, imem_we1, cpu_reset1, busy1, done1, error1;
    logic [31:0] imem_addr1, imem_wdata1;
    int checks = 0, errors = 0;
    logic [31:0] wq[$];
    logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];

    imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error));
    imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h100)) dut1 (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
        .cpu_reset(cpu_reset1), .busy(busy1), .done(done1), .error(error1));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we)  begin qa0.push_back(imem_addr);  qd0.push_back(imem_wdata);  end
        if (imem_we1) begin qa1.push_back(imem_addr1); qd1.push_back(imem_wdata1); end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1; byte_valid = 1; byte_in = 8'hFF;
        @(posedge clk); #1;
        start = 0; byte_valid = 0;
        @(negedge clk);
        chk("start_busy", {busy, done, error, byte_ready, cpu_reset}, 5'b10011);
    endtask

    task automatic send(input logic [7:0] b, input int gap, input logic with_start);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_in = b; byte_valid = 1; start = with_start;
        for (int k = 0; k < 20 && !byte_ready; k++) @(negedge clk);
        if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk); #1;
        byte_valid = 0; start = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax, input logic with_start);
        for (int j = 0; j < 4; j++) begin
            logic [31:0] t;
            t = w >> (8 * j);
            send(t[7:0], gmax == 0 ? 0 : int'($urandom_range(gmax, 0)), with_start && j == 1);
        end
    endtask

    task automatic wait_end();
        int k;
        for (k = 0; k < 40 && !(done || error); k++) @(negedge clk);
        if (!(done || error)) chk("end_timeout", 32'(done | error), 32'd1);
    endtask

    task automatic run_session(input string tag, input logic [7:0] delta, input int gmax);
        logic [7:0] cs;
        int n;
        logic ok;
        n = wq.size();
        cs = 8'h00;
        foreach (wq[i]) cs = cs ^ wq[i][7:0] ^ wq[i][15:8] ^ wq[i][23:16] ^ wq[i][31:24];
        ok = delta == 8'h00;
        clear_q();
        do_start();
        send_word(32'(n), gmax, 1'b0);
        foreach (wq[i]) send_word(wq[i], gmax, i == 1);
        send(cs ^ delta, gmax, 1'b0);
        wait_end();
        @(negedge clk);
        chk({tag, "_status"}, {busy, done, error, cpu_reset}, {1'b0, ok, !ok, !ok});
        chk({tag, "_status1"}, {busy1, done1, error1, cpu_reset1}, {1'b0, ok, !ok, !ok});
        chk({tag, "_nwr"}, 32'(qa0.size()), 32'(n));
        chk({tag, "_nwr1"}, 32'(qa1.size()), 32'(n));
        for (int i = 0; i < n && i < qa0.size() && i < qa1.size(); i++) begin
            chk({tag, "_addr"}, qa0[i], 32'(4 * i));
            chk({tag, "_data"}, qd0[i], wq[i]);
            chk({tag, "_addr1"}, qa1[i], 32'h100 + 32'(4 * i));
            chk({tag, "_data1"}, qd1[i], wq[i]);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {byte_ready, imem_we, busy, done, error, cpu_reset}, 6'b000001);
        reset = 0;
        @(negedge clk);
        chk("idle_outs", {byte_ready, imem_we, busy, done, error, cpu_reset}, 6'b000001);

        wq = '{32'h00100513, 32'h00B505B3};
        run_session("two_words", 8'h00, 0);

        clear_q();
        do_start();
        send_word(32'd257, 0, 1'b0);
        @(negedge clk);
        chk("oversize", {busy, done, error, cpu_reset, byte_ready}, 5'b00110);
        chk("oversize_nwr", 32'(qa0.size()), 32'd0);

        wq = '{$urandom()};
        run_session("bad_csum", 8'h01, 0);

        wq.delete();
        run_session("zero_len", 8'h00, 0);

        for (int s = 0; s < 4; s++) begin
            wq.delete();
            for (int i = 0; i < int'($urandom_range(6, 1)); i++) wq.push_back($urandom());
            run_session("rand", 8'h00, 5);
            run_session("rand_nogap", 8'h00, 0);
        end

        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back($urandom());
        run_session("full_depth", 8'h00, 0);

        clear_q();
        do_start();
        send_word(32'd1, 0, 1'b0);
        send(8'h11, 0, 1'b0); send(8'h22, 2, 1'b0); send(8'h33, 0, 1'b0);
        @(negedge clk);
        byte_in = 8'h44; byte_valid = 1; reset = 1;
        @(posedge clk); #1;
        byte_valid = 0; reset = 0;
        @(negedge clk);
        chk("rst_outs", {byte_ready, imem_we, busy, done, error, cpu_reset}, 6'b000001);
        repeat (2) @(negedge clk);
        chk("rst_nwr", 32'(qa0.size() + qa1.size()), 32'd0);

        wq = '{$urandom(), $urandom()};
        run_session("after_rst", 8'h00, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
